// File: rtl/data_path_pkg.sv
// Shared definitions for the data_path_pipe block: ALU op encodings,
// immediate-select bit position and the result flag bundle.
package data_path_pkg;

   // Bit of the 4-bit opcode that selects the immediate as operand B
   localparam int IMM_BIT = 3;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_AND  = 3'b010,
      OP_OR   = 3'b011,
      OP_XOR  = 3'b100,
      OP_SHL  = 3'b101,
      OP_SHR  = 3'b110,
      OP_PASS = 3'b111
   } alu_op_e;

   typedef struct packed {
      logic zero;
      logic carry;
   } flags_t;

endpackage

// File: rtl/data_path_pipe_if.sv
// Instruction-in / result-out handshake bundle for data_path_pipe.
// slave = the pipe itself, master = whoever feeds and drains it.
interface data_path_pipe_if #(
   parameter int DATA_W = 8,
   parameter int REG_AW = 3
);
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        in_opcode;
   logic [REG_AW-1:0] in_src1;
   logic [REG_AW-1:0] in_src2;
   logic [REG_AW-1:0] in_dest;
   logic [DATA_W-1:0] in_imm;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_result;
   logic [REG_AW-1:0] out_dest;
   logic              out_zero;
   logic              out_carry;

   modport slave (
      input  in_valid, in_opcode, in_src1, in_src2, in_dest, in_imm, out_ready,
      output in_ready, out_valid, out_result, out_dest, out_zero, out_carry
   );

   modport master (
      output in_valid, in_opcode, in_src1, in_src2, in_dest, in_imm, out_ready,
      input  in_ready, out_valid, out_result, out_dest, out_zero, out_carry
   );
endinterface

// File: rtl/alu_param.sv
// Combinational ALU: modulo-2**DATA_W arithmetic, logic ops, 1-bit shifts.
// carry is carry-out for ADD, borrow for SUB, shifted-out bit for shifts.
module alu_param
   import data_path_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  alu_op_e           op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] result,
   output logic              zero,
   output logic              carry
);

   logic [DATA_W:0] ext;

   // Select result and carry per op; ext holds the (DATA_W+1)-bit add/sub
   always_comb begin
      ext    = '0;
      result = '0;
      carry  = 1'b0;
      unique case (op)
         OP_ADD: begin
            ext    = {1'b0, a} + {1'b0, b};
            result = ext[DATA_W-1:0];
            carry  = ext[DATA_W];
         end
         OP_SUB: begin
            // top bit of the widened difference is set exactly when a < b
            ext    = {1'b0, a} - {1'b0, b};
            result = ext[DATA_W-1:0];
            carry  = ext[DATA_W];
         end
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_SHL: begin
            result = {a[DATA_W-2:0], 1'b0};
            carry  = a[DATA_W-1];
         end
         OP_SHR: begin
            result = {1'b0, a[DATA_W-1:1]};
            carry  = a[0];
         end
         OP_PASS: result = b;
         default: result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/data_path_pipe.sv
// Three-stage register-file datapath: RD (operand capture) -> EX (ALU)
// -> OUT (result register). The register file is written as EX moves to
// OUT, so a younger instruction captured on that same edge takes the ALU
// result through the bypass instead of the stale register value.
module data_path_pipe
   import data_path_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int REG_AW = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   data_path_pipe_if.slave   bus,
   input  logic [REG_AW-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   localparam int NREGS = 2**REG_AW;

   logic [DATA_W-1:0] rf [NREGS];

   logic              ex_vld;
   alu_op_e           ex_op;
   logic [DATA_W-1:0] ex_a;
   logic [DATA_W-1:0] ex_b;
   logic [REG_AW-1:0] ex_dest;

   logic              ex_adv;
   logic              accept;
   logic [DATA_W-1:0] rd_a;
   logic [DATA_W-1:0] rd_b;
   logic [DATA_W-1:0] alu_res;
   flags_t            alu_flg;

   alu_param #(.DATA_W(DATA_W)) u_alu (
      .op     (ex_op),
      .a      (ex_a),
      .b      (ex_b),
      .result (alu_res),
      .zero   (alu_flg.zero),
      .carry  (alu_flg.carry)
   );

   assign ex_adv       = ex_vld & (~bus.out_valid | bus.out_ready);
   assign bus.in_ready = ~ex_vld | ex_adv;
   assign accept       = bus.in_valid & bus.in_ready;
   assign dbg_data     = rf[dbg_addr];

   // Operand read with EX->RD bypass; immediate overrides operand B
   always_comb begin
      rd_a = rf[bus.in_src1];
      if (ex_adv && ex_dest == bus.in_src1) rd_a = alu_res;
      rd_b = rf[bus.in_src2];
      if (ex_adv && ex_dest == bus.in_src2) rd_b = alu_res;
      if (bus.in_opcode[IMM_BIT]) rd_b = bus.in_imm;
   end

   // Register file: written only when EX retires into OUT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      end else if (ex_adv) begin
         rf[ex_dest] <= alu_res;
      end
   end

   // EX stage: capture on accept, otherwise empty out once it has advanced
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_vld  <= 1'b0;
         ex_op   <= OP_ADD;
         ex_a    <= '0;
         ex_b    <= '0;
         ex_dest <= '0;
      end else if (accept) begin
         ex_vld  <= 1'b1;
         ex_op   <= alu_op_e'(bus.in_opcode[2:0]);
         ex_a    <= rd_a;
         ex_b    <= rd_b;
         ex_dest <= bus.in_dest;
      end else if (ex_adv) begin
         ex_vld  <= 1'b0;
      end
   end

   // OUT stage: load from EX, hold under back-pressure, clear when drained
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid  <= 1'b0;
         bus.out_result <= '0;
         bus.out_dest   <= '0;
         bus.out_zero   <= 1'b0;
         bus.out_carry  <= 1'b0;
      end else if (ex_adv) begin
         bus.out_valid  <= 1'b1;
         bus.out_result <= alu_res;
         bus.out_dest   <= ex_dest;
         bus.out_zero   <= alu_flg.zero;
         bus.out_carry  <= alu_flg.carry;
      end else if (bus.out_ready) begin
         bus.out_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_data_path_pipe.sv
// Scoreboard bench for data_path_pipe: directed instructions push their
// hand-computed results; monitors pop and compare on each retirement.
module tb_data_path_pipe;

   typedef struct {
      logic [15:0] res;
      logic [3:0]  dest;
      logic        z;
      logic        c;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [2:0]  dbg_a8  = '0;
   logic [7:0]  dbg_d8;
   logic [3:0]  dbg_a16 = '0;
   logic [15:0] dbg_d16;

   int   nvec = 0;
   int   nerr = 0;
   int   cyc  = 0;
   exp_t q8[$];
   exp_t q16[$];
   int   ret_cyc[$];

   data_path_pipe_if #(.DATA_W(8),  .REG_AW(3)) b8();
   data_path_pipe_if #(.DATA_W(16), .REG_AW(4)) b16();

   data_path_pipe #(.DATA_W(8), .REG_AW(3)) dut8 (
      .clk(clk), .rst_n(rst_n), .bus(b8.slave), .dbg_addr(dbg_a8), .dbg_data(dbg_d8));
   data_path_pipe #(.DATA_W(16), .REG_AW(4)) dut16 (
      .clk(clk), .rst_n(rst_n), .bus(b16.slave), .dbg_addr(dbg_a16), .dbg_data(dbg_d16));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitors: one retirement per negedge where out_valid & out_ready
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && b8.out_valid && b8.out_ready) begin
         if (q8.size() == 0) chk("ret8_unexpected", 32'd1, 32'd0);
         else begin
            e = q8.pop_front();
            chk("ret8", {b8.out_result, 1'b0, b8.out_dest, b8.out_zero, b8.out_carry},
                {e.res, e.dest, e.z, e.c});
            ret_cyc.push_back(cyc);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && b16.out_valid && b16.out_ready) begin
         if (q16.size() == 0) chk("ret16_unexpected", 32'd1, 32'd0);
         else begin
            e = q16.pop_front();
            chk("ret16", {b16.out_result, b16.out_dest, b16.out_zero, b16.out_carry},
                {e.res, e.dest, e.z, e.c});
         end
      end
   end

   // Issue one instruction (called at a negedge); returns at the negedge after acceptance
   task automatic send(input bit wide, input logic [3:0] op, input int s1, input int s2,
                       input int d, input logic [15:0] imm,
                       input logic [15:0] er, input logic ez, input logic ec);
      exp_t e;
      int   k = 0;
      e.res = er; e.dest = 4'(d); e.z = ez; e.c = ec;
      if (wide) begin
         q16.push_back(e);
         b16.in_opcode = op; b16.in_src1 = 4'(s1); b16.in_src2 = 4'(s2);
         b16.in_dest = 4'(d); b16.in_imm = imm; b16.in_valid = 1'b1;
         while (!b16.in_ready && k < 50) begin @(negedge clk); k++; end
      end else begin
         q8.push_back(e);
         b8.in_opcode = op; b8.in_src1 = 3'(s1); b8.in_src2 = 3'(s2);
         b8.in_dest = 3'(d); b8.in_imm = imm[7:0]; b8.in_valid = 1'b1;
         while (!b8.in_ready && k < 50) begin @(negedge clk); k++; end
      end
      if (k >= 50) chk("accept_timeout", 32'd1, 32'd0);
      @(negedge clk);
      b8.in_valid  = 1'b0;
      b16.in_valid = 1'b0;
   endtask

   task automatic drain();
      int k = 0;
      while ((q8.size() != 0 || q16.size() != 0) && k < 100) begin @(negedge clk); k++; end
      @(negedge clk);
   endtask

   task automatic dbg8(input int a, input logic [7:0] exp, input string name);
      dbg_a8 = 3'(a);
      #1 chk(name, dbg_d8, exp);
   endtask

   task automatic set_out_ready(input logic v);
      @(posedge clk);
      #1 b8.out_ready = v;
   endtask

   initial begin
      b8.in_valid = 0; b8.in_opcode = 0; b8.in_src1 = 0; b8.in_src2 = 0;
      b8.in_dest = 0; b8.in_imm = 0; b8.out_ready = 1;
      b16.in_valid = 0; b16.in_opcode = 0; b16.in_src1 = 0; b16.in_src2 = 0;
      b16.in_dest = 0; b16.in_imm = 0; b16.out_ready = 1;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_out_valid", b8.out_valid, 0);
      chk("rst_in_ready", b8.in_ready, 1);
      rst_n = 1'b1;
      @(negedge clk);

      // MOVI / ADD with carry
      send(0, 4'b1111, 0, 0, 1, 16'h00F0, 16'h00F0, 0, 0);
      send(0, 4'b1111, 0, 0, 2, 16'h0020, 16'h0020, 0, 0);
      send(0, 4'b0000, 1, 2, 3, 16'h0000, 16'h0010, 0, 1);
      drain();
      dbg8(3, 8'h10, "dbg_r3_add");
      dbg8(1, 8'hF0, "dbg_r1_movi");

      // Back-to-back bypass, both operands from the instruction ahead
      ret_cyc.delete();
      send(0, 4'b1111, 0, 0, 4, 16'h0005, 16'h0005, 0, 0);
      send(0, 4'b0001, 4, 4, 5, 16'h0000, 16'h0000, 1, 0);
      drain();
      chk("bypass_no_bubble", ret_cyc.size() == 2 ? ret_cyc[1] - ret_cyc[0] : -1, 1);

      // Borrow, shifts, logic ops
      send(0, 4'b1111, 0, 0, 1, 16'h0001, 16'h0001, 0, 0);
      send(0, 4'b1111, 0, 0, 2, 16'h0002, 16'h0002, 0, 0);
      send(0, 4'b0001, 1, 2, 6, 16'h0000, 16'h00FF, 0, 1);
      send(0, 4'b0110, 1, 0, 7, 16'h0000, 16'h0000, 1, 1);
      send(0, 4'b1111, 0, 0, 0, 16'h0080, 16'h0080, 0, 0);
      send(0, 4'b0101, 0, 0, 0, 16'h0000, 16'h0000, 1, 1);
      send(0, 4'b1010, 1, 0, 3, 16'h0003, 16'h0001, 0, 0);
      send(0, 4'b1011, 1, 0, 4, 16'h00F0, 16'h00F1, 0, 0);
      send(0, 4'b0100, 1, 1, 5, 16'h0000, 16'h0000, 1, 0);
      send(0, 4'b0000, 1, 2, 6, 16'h0000, 16'h0003, 0, 0);
      drain();
      dbg8(6, 8'h03, "dbg_r6_add");
      dbg8(7, 8'h00, "dbg_r7_shr");

      // Back-pressure: A fills OUT, B fills EX, C waits
      set_out_ready(0);
      @(negedge clk);
      ret_cyc.delete();
      send(0, 4'b1111, 0, 0, 2, 16'h0011, 16'h0011, 0, 0);
      send(0, 4'b1111, 0, 0, 3, 16'h0022, 16'h0022, 0, 0);
      fork
         send(0, 4'b0000, 2, 3, 4, 16'h0000, 16'h0033, 0, 0);
      join_none
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_in_ready", b8.in_ready, 0);
         chk("bp_hold", {b8.out_valid, b8.out_result, 1'b0, b8.out_dest}, {1'b1, 8'h11, 4'd2});
         dbg8(3, 8'h01, "bp_r3_unchanged");
         @(negedge clk);
      end
      set_out_ready(1);
      wait fork;
      drain();
      chk("bp_retired", ret_cyc.size(), 3);
      if (ret_cyc.size() == 3) chk("bp_one_per_cycle", ret_cyc[2] - ret_cyc[0], 2);
      dbg8(4, 8'h33, "dbg_r4_bp");

      // Reset mid-stream discards in-flight work and clears registers
      set_out_ready(0);
      @(negedge clk);
      send(0, 4'b1111, 0, 0, 1, 16'h0055, 16'h0055, 0, 0);
      send(0, 4'b1111, 0, 0, 2, 16'h0066, 16'h0066, 0, 0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", b8.out_valid, 0);
      chk("mid_rst_in_ready", b8.in_ready, 1);
      for (int i = 0; i < 8; i++) dbg8(i, 8'h00, "mid_rst_reg");
      q8.delete();
      b8.out_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1 chk("post_rst_in_ready", b8.in_ready, 1);
      @(negedge clk);
      send(0, 4'b1111, 0, 0, 1, 16'h003C, 16'h003C, 0, 0);
      send(0, 4'b0000, 0, 1, 2, 16'h0000, 16'h003C, 0, 0);
      drain();
      dbg8(2, 8'h3C, "dbg_r2_after_rst");

      // 16-bit / 16-register instance: wraparound ADD into r15
      send(1, 4'b1111, 0, 0, 14, 16'hFFFF, 16'hFFFF, 0, 0);
      send(1, 4'b1000, 14, 0, 15, 16'h0001, 16'h0000, 1, 1);
      drain();
      dbg_a16 = 4'd15;
      #1 chk("dbg16_r15", dbg_d16, 16'h0000);
      dbg_a16 = 4'd14;
      #1 chk("dbg16_r14", dbg_d16, 16'hFFFF);

      chk("queues_drained", q8.size() + q16.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
